// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: it feeds one operand bit pair per clock into an external
// full-adder cell and gathers the sum LSB first. It uses a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  input  logic             i_cin,
  input  logic [1:0]       i_fa_y,
  output logic             o_fa_a,
  output logic             o_fa_b,
  output logic             o_fa_c,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             w_run;

  // The cell inputs come straight from registers, so the cell settles within the clock period.
  assign w_run  = (r_state == S_RUN);
  assign o_fa_a = w_run & r_a_sr[0];
  assign o_fa_b = w_run & r_b_sr[0];
  assign o_fa_c = w_run & r_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a_sr  <= i_a_in;
            r_b_sr  <= i_b_in;
            r_c     <= i_cin;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // i_fa_y is looked at only here, so an undriven cell output in IDLE cannot reach the state.
          r_s_sr <= {i_fa_y[0], r_s_sr[WIDTH-1:1]};
          r_c    <= i_fa_y[1];
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            o_sum   <= {i_fa_y[0], r_s_sr[WIDTH-1:1]};
            o_cout  <= i_fa_y[1];
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an arithmetic timeline model with a per-cycle compare (WIDTH=8),
// plus an exhaustive WIDTH=2 sweep. Both use a behavioural full-adder cell.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         cin = 1'b0;
  logic [1:0]   fa_y;
  logic         fa_a, fa_b, fa_c, busy, done, cout;
  logic [W-1:0] sum;

  logic         start2 = 1'b0;
  logic [1:0]   a2 = '0, b2 = '0;
  logic         cin2 = 1'b0;
  logic [1:0]   fa_y2;
  logic         fa_a2, fa_b2, fa_c2, busy2, done2, cout2;
  logic [1:0]   sum2;

  int errors = 0;
  int checks = 0;

  always #50 clk = ~clk;

  assign fa_y  = {(fa_a & fa_b) | (fa_c & (fa_a ^ fa_b)), fa_a ^ fa_b ^ fa_c};
  assign fa_y2 = {(fa_a2 & fa_b2) | (fa_c2 & (fa_a2 ^ fa_b2)), fa_a2 ^ fa_b2 ^ fa_c2};

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a_in(a_in), .i_b_in(b_in), .i_cin(cin),
    .i_fa_y(fa_y), .o_fa_a(fa_a), .o_fa_b(fa_b), .o_fa_c(fa_c), .o_busy(busy), .o_done(done),
    .o_sum(sum), .o_cout(cout));

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_a_in(a2), .i_b_in(b2), .i_cin(cin2),
    .i_fa_y(fa_y2), .o_fa_a(fa_a2), .o_fa_b(fa_b2), .o_fa_c(fa_c2), .o_busy(busy2), .o_done(done2),
    .o_sum(sum2), .o_cout(cout2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: m_t is the number of edges since the accepting edge (-1 means idle).
  int       m_t = -1;
  bit       m_valid = 0;
  int       m_a, m_b, m_ci;
  int       m_sum = 0, m_cout = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_t = -1; m_sum = 0; m_cout = 0; m_valid = 1;
    end else if (m_t < 0) begin
      if (start) begin
        m_a = int'(a_in); m_b = int'(b_in); m_ci = int'(cin); m_t = 1;
      end
    end else if (m_t == W + 1) begin
      m_t = -1;
    end else begin
      m_t++;
      if (m_t == W + 1) begin
        m_sum  = (m_a + m_b + m_ci) & ((1 << W) - 1);
        m_cout = (m_a + m_b + m_ci) >> W;
      end
    end
  end

  int cyc = 0;
  int last_done = -1;
  int done_gap = 0;

  always @(negedge clk) begin
    int i, msk;
    cyc++;
    if (m_valid) begin
      chk("busy", int'(busy), int'(m_t >= 1 && m_t <= W));
      chk("done", int'(done), int'(m_t == W + 1));
      chk("sum",  int'(sum),  m_sum);
      chk("cout", int'(cout), m_cout);
      if (m_t >= 1 && m_t <= W) begin
        i = m_t - 1;
        msk = (1 << i) - 1;
        chk("fa_a", int'(fa_a), (m_a >> i) & 1);
        chk("fa_b", int'(fa_b), (m_b >> i) & 1);
        chk("fa_c", int'(fa_c), (((m_a & msk) + (m_b & msk) + m_ci) >> i) & 1);
      end else begin
        chk("fa_idle", int'({fa_a, fa_b, fa_c}), 0);
      end
      if (done) begin
        if (last_done >= 0) done_gap = cyc - last_done;
        last_done = cyc;
      end
    end
  end

  // Start one operation. The latency is counted in negedges after the accepting edge up to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output int lat);
    @(negedge clk);
    a_in = a; b_in = b; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 30) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, bcnt, seen_done, k;
    logic [2:0] exp3;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sum", int'({cout, sum}), 0);
    chk("reset_fa", int'({fa_a, fa_b, fa_c}), 0);
    rst = 1'b0;

    // 1: basic add, latency of WIDTH cycles
    run_op(8'h5A, 8'h3C, 1'b0, lat);
    chk("t1_latency", lat, 8);
    chk("t1_sum", int'(sum), 'h96);
    chk("t1_cout", int'(cout), 0);

    // 2: carry-out cases
    run_op(8'hFF, 8'h01, 1'b0, lat);
    chk("t2a_sum", int'({cout, sum}), 'h100);
    run_op(8'hFF, 8'hFF, 1'b1, lat);
    chk("t2b_sum", int'({cout, sum}), 'h1FF);

    // 3: a second start during RUN is ignored
    @(negedge clk);
    a_in = 8'hA5; b_in = 8'h5A; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bcnt = 0; lat = 0;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      if (lat == 2) begin a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("t3_busy_cycles", bcnt, 8);
    chk("t3_sum", int'({cout, sum}), 'h100);

    // 4: reset during RUN aborts without a done pulse
    @(negedge clk);
    a_in = 8'h77; b_in = 8'h11; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_busy", int'(busy), 0);
    chk("t4_sum", int'({cout, sum}), 0);
    chk("t4_fa", int'({fa_a, fa_b, fa_c}), 0);
    rst = 1'b0;
    seen_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("t4_no_done", seen_done, 0);
    run_op(8'h10, 8'h20, 1'b0, lat);
    chk("t4_sum_after", int'({cout, sum}), 'h030);

    // 5: start held high, producing back-to-back operations
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
    for (k = 0; k < 3; k++) begin
      lat = 0;
      @(negedge clk);
      while (!done && lat < 30) begin @(negedge clk); lat++; end
      if (lat >= 30) chk("t5_timeout", 0, 1);
      case (k)
        0: begin chk("t5_r0", int'({cout, sum}), 'h046); a_in = 8'h80; b_in = 8'h80; cin = 1'b1; end
        1: begin chk("t5_r1", int'({cout, sum}), 'h101); chk("t5_gap1", done_gap, W + 2);
                 a_in = 8'hC3; b_in = 8'h3C; cin = 1'b0; end
        default: begin chk("t5_r2", int'({cout, sum}), 'h0FF); chk("t5_gap2", done_gap, W + 2); end
      endcase
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // 6: exhaustive WIDTH=2
    for (int v = 0; v < 32; v++) begin
      @(negedge clk);
      a2 = v[1:0]; b2 = v[3:2]; cin2 = v[4]; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; lat = 0;
      while (!done2 && lat < 10) begin @(negedge clk); lat++; end
      exp3 = 3'(v[1:0]) + 3'(v[3:2]) + 3'(v[4]);
      chk("t6_latency", lat, 2);
      chk("t6_sum", int'({cout2, sum2}), int'(exp3));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
